// File: rtl/reg_operand_fetch_pkg.sv
// Shared constants for the register read / operand fetch stage: default widths
// and the op class encodings carried through to execute untouched.
package reg_operand_fetch_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_OPW   = 9;
  localparam int REG_IDX_W = 5;

  // One-hot op classes; this stage never decodes them, it only forwards them.
  localparam logic [DEF_OPW-1:0] OP_MRI = 9'b0_0000_0001;
  localparam logic [DEF_OPW-1:0] OP_IJ  = 9'b0_0000_0010;
  localparam logic [DEF_OPW-1:0] OP_I2  = 9'b0_0000_0100;
  localparam logic [DEF_OPW-1:0] OP_U   = 9'b0_0000_1000;
  localparam logic [DEF_OPW-1:0] OP_J   = 9'b0_0001_0000;

endpackage

// File: rtl/reg_operand_fetch_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, synchronous active-high reset.
module reg_file_2r1w
  import reg_operand_fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch: reads both sources with writeback bypass, holds instructions off
// on RAW/WAW hazards via a pending-write scoreboard, registers the bundle for execute.
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int OPW  = DEF_OPW,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_rd_we,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [RW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            stall
);

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rd;
    logic            rd_we;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } bundle_t;

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] pend_eff;
  logic            out_valid_q, out_valid_d;
  bundle_t         bundle_q, bundle_d;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard;
  logic            accept;

  reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (in_rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (in_rs2),
    .rdata2 (rf_rdata2)
  );

  // A writeback landing this cycle retires its register's hazard immediately.
  assign wb_clr   = wb_en ? (NREG'(1) << wb_rd) : '0;
  assign pend_eff = pending_q & ~wb_clr;
  assign hazard   = pend_eff[in_rs1] | pend_eff[in_rs2] | (in_rd_we & pend_eff[in_rd]);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a valid producer holds its payload until that edge.
  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign stall    = in_valid & hazard;

  always_comb begin
    rs1_val = rf_rdata1;
    if (in_rs1 == '0)                  rs1_val = '0;
    else if (wb_en && (wb_rd == in_rs1)) rs1_val = wb_data;
    rs2_val = rf_rdata2;
    if (in_rs2 == '0)                  rs2_val = '0;
    else if (wb_en && (wb_rd == in_rs2)) rs2_val = wb_data;
  end

  always_comb begin
    pending_d   = pend_eff;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    // Setting after clearing lets a new producer win over a retiring one.
    if (accept && in_rd_we && (in_rd != '0)) pending_d[in_rd] = 1'b1;
    if (accept) begin
      out_valid_d       = 1'b1;
      bundle_d.op       = in_op;
      bundle_d.rd       = in_rd;
      bundle_d.rd_we    = in_rd_we & (in_rd != '0);
      bundle_d.rs1_data = rs1_val;
      bundle_d.rs2_data = rs2_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_op       = bundle_q.op;
  assign out_rd       = bundle_q.rd;
  assign out_rd_we    = bundle_q.rd_we;
  assign out_rs1_data = bundle_q.rs1_data;
  assign out_rs2_data = bundle_q.rs2_data;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench for reg_operand_fetch: directed scenarios plus a randomized
// run against a behavioural model of the register file, scoreboard and output stage.
module tb_reg_operand_fetch;
  import reg_operand_fetch_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid, in_ready, in_rd_we;
  logic [8:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, out_rd_we, stall;
  logic [8:0]  out_op;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_data, out_rs2_data;

  reg_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .stall(stall)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model
  typedef struct packed {
    logic [8:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic [31:0] m_rf [32];
  bit          m_pend [32];
  exp_t        exp_q [$];

  function automatic bit m_busy(input int r);
    return (r != 0) && m_pend[r] && !(wb_en && (int'(wb_rd) == r));
  endfunction

  function automatic bit m_hazard();
    return m_busy(int'(in_rs1)) || m_busy(int'(in_rs2)) || (in_rd_we && m_busy(int'(in_rd)));
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && ((exp_q.size() == 0) || out_ready);
  endfunction

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (wb_en && (int'(wb_rd) == r)) return wb_data;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // advance one clock, updating the model with the pre-edge inputs
  task automatic tick();
    bit   acc, consume;
    exp_t b;
    acc     = in_valid && m_ready();
    consume = (exp_q.size() != 0) && out_ready;
    b = '{op: in_op, rd: in_rd, we: in_rd_we && (in_rd != 5'd0),
          d1: m_read(int'(in_rs1)), d2: m_read(int'(in_rs2))};
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (wb_en && (wb_rd != 5'd0)) begin
        m_rf[wb_rd]   = wb_data;
        m_pend[wb_rd] = 1'b0;
      end
      if (acc && in_rd_we && (in_rd != 5'd0)) m_pend[in_rd] = 1'b1;
      if (consume) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(b);
    end
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid = 0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 0;
  endtask

  task automatic drive_issue(input logic [8:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic we);
    in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 1;
    drive_idle(); drive_wb(0, 0, 0);
    model_reset();
    tick(); tick();
    rst = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if ({out_op, out_rd, out_rd_we, out_rs1_data, out_rs2_data} !== '0) begin
      n_err++; $display("FAIL reset_bundle: got %h/%h/%b/%h/%h expected all 0", out_op, out_rd, out_rd_we, out_rs1_data, out_rs2_data); end
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL reset_ready: got ready=%b stall=%b expected 1/0", in_ready, stall); end
  endtask

  task automatic test_bypass_read();
    drive_wb(1, 5, 32'h1234);
    tick();
    drive_wb(0, 0, 0);
    drive_issue(OP_I2, 5, 0, 3, 0);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h1234 || out_rs2_data !== 32'h0) begin
      n_err++; $display("FAIL read_x5: got v=%b rs1=%h rs2=%h expected 1/00001234/00000000", out_valid, out_rs1_data, out_rs2_data); end
    n_vec++; if (out_op !== OP_I2 || out_rd !== 5'd3 || out_rd_we !== 1'b0) begin
      n_err++; $display("FAIL read_x5_ctl: got op=%h rd=%0d we=%b expected %h/3/0", out_op, out_rd, out_rd_we, OP_I2); end
    drive_wb(1, 5, 32'hBEEF);
    drive_issue(OP_I2, 0, 5, 0, 0);
    tick();
    drive_wb(0, 0, 0); drive_idle();
    n_vec++; if (out_rs2_data !== 32'hBEEF) begin n_err++; $display("FAIL bypass_rs2: got %h expected 0000beef", out_rs2_data); end
    tick();
  endtask

  task automatic test_raw_stall();
    drive_issue(OP_MRI, 0, 0, 7, 1);
    tick();
    drive_issue(OP_IJ, 7, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall0: got stall=%b ready=%b expected 1/0", stall, in_ready); end
    tick();
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall1: got %b expected 1", stall); end
    drive_wb(1, 7, 32'hDEAD);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got stall=%b ready=%b expected 0/1", stall, in_ready); end
    tick();
    drive_wb(0, 0, 0); drive_idle();
    n_vec++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hDEAD || out_op !== OP_IJ) begin
      n_err++; $display("FAIL raw_data: got v=%b rs1=%h op=%h expected 1/0000dead/%h", out_valid, out_rs1_data, out_op, OP_IJ); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive_issue(OP_U, 5, 7, 0, 0);
    tick();
    drive_issue(OP_J, 7, 5, 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_op !== OP_U || out_rs1_data !== 32'hBEEF || out_rs2_data !== 32'hDEAD) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b op=%h rs1=%h rs2=%h expected 1/%h/0000beef/0000dead",
                          i, out_valid, out_op, out_rs1_data, out_rs2_data, OP_U); end
    end
    out_ready = 1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    tick();
    drive_idle();
    n_vec++; if (out_valid !== 1'b1 || out_op !== OP_J || out_rs1_data !== 32'hDEAD || out_rd !== 5'd2 || out_rd_we !== 1'b1) begin
      n_err++; $display("FAIL bp_next: got v=%b op=%h rs1=%h rd=%0d we=%b expected 1/%h/0000dead/2/1",
                        out_valid, out_op, out_rs1_data, out_rd, out_rd_we, OP_J); end
    drive_wb(1, 2, 32'h22);
    tick();
    drive_wb(0, 0, 0);
  endtask

  task automatic test_x0();
    drive_issue(OP_I2, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_rd_we !== 1'b0) begin n_err++; $display("FAIL x0_rd_we: got %b expected 0", out_rd_we); end
    drive_issue(OP_I2, 0, 0, 4, 0);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_nostall: got %b expected 0", stall); end
    drive_wb(1, 0, 32'hFFFF_FFFF);
    tick();
    n_vec++; if (out_rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_bypass: got %h expected 00000000", out_rs1_data); end
    drive_wb(0, 0, 0);
    drive_issue(OP_I2, 0, 0, 0, 0);
    tick();
    drive_idle();
    n_vec++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin
      n_err++; $display("FAIL x0_read: got %h/%h expected 0/0", out_rs1_data, out_rs2_data); end
    tick();
  endtask

  task automatic test_waw();
    drive_issue(OP_MRI, 0, 0, 3, 1);
    tick();
    drive_issue(OP_MRI, 0, 0, 3, 1);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_stall: got %b expected 1", stall); end
    drive_wb(1, 3, 32'h33);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL waw_accept: got stall=%b ready=%b expected 0/1", stall, in_ready); end
    tick();
    drive_wb(0, 0, 0);
    drive_issue(OP_IJ, 3, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_still_pending: got %b expected 1", stall); end
    drive_wb(1, 3, 32'h44);
    tick();
    drive_wb(0, 0, 0); drive_idle();
    n_vec++; if (out_rs1_data !== 32'h44) begin n_err++; $display("FAIL waw_data: got %h expected 00000044", out_rs1_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drive_issue(OP_MRI, 0, 0, 9, 1);
    tick();
    drive_idle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre: got %b expected 1", out_valid); end
    rst = 1;
    tick();
    rst = 0; out_ready = 1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    drive_issue(OP_IJ, 9, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_stall: got %b expected 0", stall); end
    tick();
    drive_idle();
    n_vec++; if (out_rs1_data !== 32'h0) begin n_err++; $display("FAIL rm_read: got %h expected 00000000", out_rs1_data); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 9'($urandom);
      in_rs1 = 5'($urandom_range(0, 7));
      in_rs2 = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 7));
      in_rd_we = $urandom_range(0, 1);
      wb_en = ($urandom_range(0, 1) == 1);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_vec++; if (in_ready !== m_ready() || stall !== (in_valid && m_hazard())) begin
        n_err++; $display("FAIL rnd_hs[%0d]: got ready=%b stall=%b expected %b/%b", i, in_ready, stall, m_ready(), in_valid && m_hazard()); end
      tick();
      n_vec++; if (out_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if ({out_op, out_rd, out_rd_we, out_rs1_data, out_rs2_data} !== exp_q[0]) begin
          n_err++; $display("FAIL rnd_bundle[%0d]: got %h/%h/%b/%h/%h expected %h/%h/%b/%h/%h", i,
                            out_op, out_rd, out_rd_we, out_rs1_data, out_rs2_data,
                            exp_q[0].op, exp_q[0].rd, exp_q[0].we, exp_q[0].d1, exp_q[0].d2); end
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_bypass_read();
    test_raw_stall();
    test_backpressure();
    test_x0();
    test_waw();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
